// File: rtl/muldiv_hilo_if.sv
// muldiv_hilo_if: decode/operand request bus and HI/LO read-back for the muldiv unit
interface muldiv_hilo_if #(parameter int WIDTH = 32);
  logic             muldiv_op;
  logic             mul0_div1_sel;
  logic             hilo_mov_op;
  logic             hi0_lo1_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hilo_rd;
  logic             busy;
  logic             stall;
  modport master (output muldiv_op, mul0_div1_sel, hilo_mov_op, hi0_lo1_sel, a, b,
                  input hilo_rd, busy, stall);
  modport slave (input muldiv_op, mul0_div1_sel, hilo_mov_op, hi0_lo1_sel, a, b,
                 output hilo_rd, busy, stall);
endinterface

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative MULTU/DIVU engine with HI/LO registers and hazard stall.
// Define MUL_SINGLE_CYCLE_EN to commit multiplies in one cycle at the accept edge.
module muldiv_hilo_unit #(parameter int WIDTH = 32) (
  input logic           clk,
  input logic           rst,
  muldiv_hilo_if.slave  s
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [0:0] state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic div_q, div_d;
  logic busy, start, fast_mul;
  logic [2*WIDTH-1:0] fast_prod, mul_next, div_next;
  logic [WIDTH:0] mul_sum, div_shift, div_diff;
  logic div_ge;
`ifdef MUL_SINGLE_CYCLE_EN
  assign fast_mul = !s.mul0_div1_sel;
  assign fast_prod = {{WIDTH{1'b0}}, s.a} * {{WIDTH{1'b0}}, s.b};
`else
  assign fast_mul = 1'b0;
  assign fast_prod = '0;
`endif
  assign busy = state_q == RUN;
  assign start = !busy && s.muldiv_op;
  // multiply: acc = {partial, multiplier}, add multiplicand on LSB then shift right
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, acc_q[0] ? a_q : {WIDTH{1'b0}}};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  // divide: acc = {remainder, dividend/quotient}, restoring step per cycle
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge = div_shift >= {1'b0, b_q};
  assign div_diff = div_shift - {1'b0, b_q};
  assign div_next = {div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d = acc_q;
    a_d = a_q;
    b_d = b_q;
    div_d = div_q;
    hi_d = hi_q;
    lo_d = lo_q;
    if (start && fast_mul) begin
      {hi_d, lo_d} = fast_prod;
    end else if (start) begin
      state_d = RUN;
      count_d = '0;
      a_d = s.a;
      b_d = s.b;
      div_d = s.mul0_div1_sel;
      acc_d = {{WIDTH{1'b0}}, s.mul0_div1_sel ? s.a : s.b};
    end else if (busy) begin
      acc_d = div_q ? div_next : mul_next;
      count_d = count_q + 1'b1;
      if (count_q == LAST) begin
        state_d = IDLE;
        {hi_d, lo_d} = acc_d;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      div_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q <= acc_d;
      a_q <= a_d;
      b_q <= b_d;
      div_q <= div_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
  assign s.busy = busy;
  assign s.stall = busy && (s.muldiv_op || s.hilo_mov_op);
  assign s.hilo_rd = s.hi0_lo1_sel ? lo_q : hi_q;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit: directed self-checking bench for muldiv_hilo_unit.
module tb_muldiv_hilo_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int n;
`ifdef MUL_SINGLE_CYCLE_EN
  localparam int MUL_CYC = 0;
`else
  localparam int MUL_CYC = 32;
`endif
  muldiv_hilo_if #(.WIDTH(32)) bus ();
  muldiv_hilo_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .s(bus));
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic rd(input string tag, input logic sel, input logic [31:0] exp);
    bus.hi0_lo1_sel = sel;
    #1;
    chk(tag, {32'h0, bus.hilo_rd}, {32'h0, exp});
  endtask
  task automatic run_op(input string tag, input logic div, input logic [31:0] a, input logic [31:0] b,
                        input int cyc);
    bus.muldiv_op = 1'b1;
    bus.mul0_div1_sel = div;
    bus.a = a;
    bus.b = b;
    step();
    bus.muldiv_op = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      step();
    end
    chk(tag, 64'(n), 64'(cyc));
  endtask
  initial begin
    bus.muldiv_op = 1'b0;
    bus.mul0_div1_sel = 1'b0;
    bus.hilo_mov_op = 1'b0;
    bus.hi0_lo1_sel = 1'b0;
    bus.a = '0;
    bus.b = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset_busy", {63'h0, bus.busy}, 64'h0);
    chk("reset_stall", {63'h0, bus.stall}, 64'h0);
    rd("reset_hi", 1'b0, 32'h0);
    rd("reset_lo", 1'b1, 32'h0);
    run_op("mul_max_cycles", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_CYC);
    rd("mul_max_hi", 1'b0, 32'hFFFF_FFFE);
    rd("mul_max_lo", 1'b1, 32'h0000_0001);
    run_op("div_100_7_cycles", 1'b1, 32'd100, 32'd7, 32);
    bus.hilo_mov_op = 1'b1;
    rd("mflo_100_7", 1'b1, 32'd14);
    rd("mfhi_100_7", 1'b0, 32'd2);
    chk("mov_idle_stall", {63'h0, bus.stall}, 64'h0);
    bus.hilo_mov_op = 1'b0;
    run_op("div0_cycles", 1'b1, 32'h1234_5678, 32'h0, 32);
    rd("div0_lo", 1'b1, 32'hFFFF_FFFF);
    rd("div0_hi", 1'b0, 32'h1234_5678);
    bus.muldiv_op = 1'b1;
    bus.mul0_div1_sel = 1'b1;
    bus.a = 32'd9;
    bus.b = 32'd2;
    step();
    bus.muldiv_op = 1'b0;
    bus.hilo_mov_op = 1'b1;
    bus.hi0_lo1_sel = 1'b0;
    #1;
    chk("mfhi_hold_old", {32'h0, bus.hilo_rd}, {32'h0, 32'h1234_5678});
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      step();
    end
    chk("mfhi_stall_cycles", 64'(n), 64'd32);
    chk("mfhi_9_2", {32'h0, bus.hilo_rd}, 64'd1);
    bus.hilo_mov_op = 1'b0;
    bus.muldiv_op = 1'b1;
    bus.mul0_div1_sel = 1'b0;
    bus.a = 32'd3;
    bus.b = 32'd5;
    step();
    bus.mul0_div1_sel = 1'b1;
    bus.a = 32'd20;
    bus.b = 32'd6;
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      step();
    end
    chk("b2b_stall_cycles", 64'(n), 64'(MUL_CYC));
    rd("b2b_mul_lo", 1'b1, 32'd15);
    rd("b2b_mul_hi", 1'b0, 32'd0);
    step();
    bus.muldiv_op = 1'b0;
    chk("b2b_div_accept", {63'h0, bus.busy}, 64'h1);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      step();
    end
    chk("b2b_div_cycles", 64'(n), 64'd32);
    rd("b2b_div_lo", 1'b1, 32'd3);
    rd("b2b_div_hi", 1'b0, 32'd2);
    bus.muldiv_op = 1'b1;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    step();
    bus.muldiv_op = 1'b0;
    repeat (10) step();
    chk("mid_div_busy", {63'h0, bus.busy}, 64'h1);
    rst = 1'b1;
    bus.hilo_mov_op = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_mid_busy", {63'h0, bus.busy}, 64'h0);
    chk("rst_mid_stall", {63'h0, bus.stall}, 64'h0);
    rd("rst_mid_hi", 1'b0, 32'h0);
    rd("rst_mid_lo", 1'b1, 32'h0);
    step();
    chk("rst_mid_after", {63'h0, bus.busy}, 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
